specdrum_multi: RTL and testbench



---
 rtl/specdrum_pkg.sv | 21 ++
 rtl/specdrum_fifo.sv | 109 ++++++++++
 rtl/specdrum_multi.sv | 154 +++++++++++++++
 tb/tb_specdrum_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/specdrum_pkg.sv
// Shared definitions for the multi-channel Specdrum sample latch.
// Contents: clog2 helper, control register bit positions, the silence
// level used for reset, and the low address nibble of the control port.
package specdrum_pkg;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int         MODE_BIT    = 0;
  localparam int         CLR_BIT     = 1;
  localparam logic [7:0] SILENCE     = 8'h80;
  localparam logic [3:0] CTRL_NIBBLE = 4'h0;

endpackage

// File: rtl/specdrum_fifo.sv
// Per-channel sample FIFO of DEPTH 8-bit entries.
// Ports:
//   clock, reset  : system clock, asynchronous active-low reset
//   push, pop     : enqueue din / dequeue head. A push while full and a
//                   pop while empty are ignored. Both are judged against
//                   the occupancy before the edge.
//   flush         : empties the FIFO and overrides push/pop
//   din           : sample to enqueue
//   head          : registered copy of the oldest entry
//   empty, full   : registered occupancy flags
module specdrum_fifo
  import specdrum_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [AW:0]   count_r, count_next_s;
  logic          push_ok_s, pop_ok_s;
  logic [7:0]    head_r, head_next_s;
  logic          empty_r, full_r;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Next pointers, occupancy and head value.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    head_next_s   = head_r;
    if (flush) begin
      wr_ptr_next_s = '0;
      rd_ptr_next_s = '0;
      count_next_s  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_next_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_next_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_next_s = count_r + (AW+1)'(1);
        2'b01:   count_next_s = count_r - (AW+1)'(1);
        default: count_next_s = count_r;
      endcase
      // The incoming sample becomes the head when it lands in the slot
      // the read pointer will point at (FIFO empty after this edge's pop).
      if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
        head_next_s = din;
      end else begin
        head_next_s = mem_r[rd_ptr_next_s];
      end
    end
  end

  // Storage array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= SILENCE;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy, flags and head register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= SILENCE;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      empty_r  <= (count_next_s == (AW+1)'(0));
      full_r   <= (count_next_s == (AW+1)'(DEPTH));
    end
  end

  assign head  = head_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/specdrum_multi.sv
// Multi-channel 8-bit sample DAC latch on the Z80 I/O bus.
// Ports:
//   clock, reset   : system clock, asynchronous active-low reset
//   ce             : clock enable for all state changes
//   iorq, wr       : Z80 strobes, active low
//   a, d           : address bits 7:0 and data bus
//   tick           : sample-rate strobe (buffered mode only)
//   q              : channel levels, channel c at bits 8c+7:8c
//   mix            : registered unsigned sum of all channel levels
//   mode           : 0 direct, 1 buffered
//   empty, full    : per-channel FIFO flags
//   ovf, unf       : sticky overflow / underrun flags
// Port a[3:0] = F-c addresses channel c; a[3:0] = 0 is the control register.
module specdrum_multi
  import specdrum_pkg::*;
#(
  parameter int         NCH   = 4,
  parameter int         DEPTH = 16,
  parameter logic [3:0] PORT  = 4'hD
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      iorq,
  input  logic                      wr,
  input  logic [7:0]                a,
  input  logic [7:0]                d,
  input  logic                      tick,
  output logic [8*NCH-1:0]          q,
  output logic [8+clog2(NCH)-1:0]   mix,
  output logic                      mode,
  output logic [NCH-1:0]            empty,
  output logic [NCH-1:0]            full,
  output logic                      ovf,
  output logic                      unf
);

  localparam int MW = 8 + clog2(NCH);

  logic           wsel_s, fire_s, ctrl_wr_s, clr_s, flush_s, tick_s;
  logic           ovf_set_s, unf_set_s;
  logic           seen_r, mode_r, ovf_r, unf_r;
  logic [NCH-1:0] ch_wr_s, push_s, pop_s, empty_s, full_s;
  logic [7:0]     head_s [NCH];
  logic [7:0]     q_r [NCH];
  logic [MW-1:0]  sum_s, mix_r;

  assign wsel_s    = !iorq && !wr && (a[7:4] == PORT);
  // One event per strobe: fire only when the previous ce sample was idle.
  assign fire_s    = ce && wsel_s && !seen_r;
  assign ctrl_wr_s = fire_s && (a[3:0] == CTRL_NIBBLE);
  assign clr_s     = ctrl_wr_s && d[CLR_BIT];
  assign flush_s   = ctrl_wr_s && (d[MODE_BIT] != mode_r);
  // A tick coinciding with a mode change is dropped along with the FIFO data.
  assign tick_s    = ce && tick && mode_r && !flush_s;
  assign ovf_set_s = |(push_s & full_s);
  assign unf_set_s = tick_s && (|empty_s);

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      assign ch_wr_s[c] = fire_s && (a[3:0] == 4'(15 - c));
      assign push_s[c]  = ch_wr_s[c] && mode_r;
      assign pop_s[c]   = tick_s;
      assign q[8*c +: 8] = q_r[c];

      specdrum_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s[c]),
        .pop   (pop_s[c]),
        .flush (flush_s),
        .din   (d),
        .head  (head_s[c]),
        .empty (empty_s[c]),
        .full  (full_s[c])
      );
    end
  endgenerate

  // Strobe history; starts "seen" so a strobe held through reset is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen_r <= 1'b1;
    end else if (ce) begin
      seen_r <= wsel_s;
    end
  end

  // Control register and sticky flags (a set beats a clear on the same edge).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_r <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else if (ce) begin
      if (ctrl_wr_s) begin
        mode_r <= d[MODE_BIT];
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_s) begin
        ovf_r <= 1'b0;
      end
      if (unf_set_s) begin
        unf_r <= 1'b1;
      end else if (clr_s) begin
        unf_r <= 1'b0;
      end
    end
  end

  // Channel level registers: direct writes or FIFO pops on tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        q_r[i] <= SILENCE;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_wr_s[i] && !mode_r) begin
          q_r[i] <= d;
        end else if (pop_s[i] && !empty_s[i]) begin
          q_r[i] <= head_s[i];
        end
      end
    end
  end

  // Adder over all channel levels.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_s = sum_s + MW'(q_r[i]);
    end
  end

  // Mix register, follows q one ce edge later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mix_r <= MW'(NCH * 128);
    end else if (ce) begin
      mix_r <= sum_s;
    end
  end

  assign mix   = mix_r;
  assign mode  = mode_r;
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

endmodule

// File: tb/tb_specdrum_multi.sv
// Directed self-checking bench for specdrum_multi (NCH=4, DEPTH=16).
// A per-channel queue holds samples expected to be played out; ticks pop
// them and compare against the channel levels.
module tb_specdrum_multi;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset, ce, iorq, wr, tick;
  logic [7:0]  a, d;
  logic [31:0] q;
  logic [9:0]  mix;
  logic        mode, ovf, unf;
  logic [3:0]  empty, full;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] qm [4];
  logic [7:0] sb [4][$];
  logic       mode_m, ovf_m, unf_m;

  always #5 clock = ~clock;

  specdrum_multi #(.NCH(NCH), .DEPTH(DEPTH), .PORT(4'hD)) dut (
    .clock (clock), .reset (reset), .ce (ce), .iorq (iorq), .wr (wr),
    .a (a), .d (d), .tick (tick), .q (q), .mix (mix), .mode (mode),
    .empty (empty), .full (full), .ovf (ovf), .unf (unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qvec();
    return {qm[3], qm[2], qm[1], qm[0]};
  endfunction

  function automatic logic [31:0] qsum();
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < NCH; i++) s = s + 32'(qm[i]);
    return s;
  endfunction

  function automatic logic [31:0] empty_m();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < NCH; i++) v[i] = (sb[i].size() == 0);
    return v;
  endfunction

  function automatic logic [31:0] full_m();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < NCH; i++) v[i] = (sb[i].size() == DEPTH);
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_q"}, q, qvec());
    check({tag, "_flags"}, 32'({mode, ovf, unf}), 32'({mode_m, ovf_m, unf_m}));
    check({tag, "_empty"}, 32'(empty), empty_m());
    check({tag, "_full"}, 32'(full), full_m());
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      qm[i] = 8'h80;
      sb[i].delete();
    end
    mode_m = 1'b0;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
  endtask

  task automatic model_tick();
    if (mode_m) begin
      for (int i = 0; i < NCH; i++) begin
        if (sb[i].size() > 0) qm[i] = sb[i].pop_front();
        else unf_m = 1'b1;
      end
    end
  endtask

  // pre_sz: occupancy of the addressed channel before the edge.
  task automatic model_write(input logic [3:0] lo, input logic [7:0] val, input int pre_sz);
    int ch;
    if (lo == 4'h0) begin
      if (val[0] != mode_m) begin
        for (int i = 0; i < NCH; i++) sb[i].delete();
      end
      mode_m = val[0];
      if (val[1]) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
    end else if (lo >= 4'hC) begin
      ch = 15 - int'(lo);
      if (!mode_m) qm[ch] = val;
      else if (pre_sz < DEPTH) sb[ch].push_back(val);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int pre_size(input logic [3:0] lo);
    if (lo >= 4'hC) return sb[15 - int'(lo)].size();
    return 0;
  endfunction

  task automatic do_write(input logic [3:0] lo, input logic [7:0] val, input string tag);
    int pre;
    pre = pre_size(lo);
    iorq = 1'b0; wr = 1'b0; a = {4'hD, lo}; d = val;
    cyc(1);
    model_write(lo, val, pre);
    check_all(tag);
    iorq = 1'b1; wr = 1'b1;
    cyc(1);
  endtask

  task automatic do_tick(input string tag);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    model_tick();
    check_all(tag);
  endtask

  task automatic tick_write(input logic [3:0] lo, input logic [7:0] val, input string tag);
    int pre;
    pre = pre_size(lo);
    iorq = 1'b0; wr = 1'b0; a = {4'hD, lo}; d = val; tick = 1'b1;
    cyc(1);
    model_tick();
    model_write(lo, val, pre);
    check_all(tag);
    iorq = 1'b1; wr = 1'b1; tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b0; ce = 1'b1; iorq = 1'b1; wr = 1'b1; tick = 1'b0;
    a = 8'h00; d = 8'h00;
    model_reset();
    #23;
    check_all("reset");
    check("reset_mix", 32'(mix), 32'd512);
    reset = 1'b1;
    cyc(2);

    // Held direct write to xxDF: one event only.
    iorq = 1'b0; wr = 1'b0; a = 8'hDF; d = 8'h3C;
    cyc(1);
    qm[0] = 8'h3C;
    check_all("direct_first");
    check("direct_mix_lag", 32'(mix), 32'd512);
    d = 8'h55;
    cyc(1);
    check("direct_mix", 32'(mix), 32'h1BC);
    cyc(3);
    check_all("direct_held");

    // Strobe gap seen only while ce=0 must not re-arm the detector.
    ce = 1'b0; iorq = 1'b1; wr = 1'b1;
    cyc(1);
    iorq = 1'b0; wr = 1'b0; d = 8'h66;
    cyc(1);
    ce = 1'b1;
    cyc(1);
    check_all("ce_gate");
    iorq = 1'b1; wr = 1'b1;
    cyc(1);

    do_tick("tick_direct");

    // Buffered playback on channel 1.
    do_write(4'h0, 8'h01, "mode_on");
    do_write(4'hE, 8'h10, "push1a");
    do_write(4'hE, 8'h20, "push1b");
    do_tick("tick1");
    do_tick("tick2");
    do_tick("tick3_unf");
    do_write(4'h0, 8'h03, "clr1");

    // Overfill channel 2 and replay.
    for (int i = 0; i <= DEPTH; i++) do_write(4'hD, 8'hA0 + 8'(i), "fill2");
    for (int i = 0; i < DEPTH; i++) do_tick("replay2");
    do_write(4'h0, 8'h03, "clr2");

    // Simultaneous tick and push: full channel, then empty channel.
    for (int i = 0; i < DEPTH; i++) do_write(4'hC, 8'hC0 + 8'(i), "fill3");
    tick_write(4'hC, 8'hEE, "tw_full");
    do_write(4'h0, 8'h03, "clr3");
    tick_write(4'hF, 8'h77, "tw_empty");
    do_tick("tw_next");

    // Mode change with data buffered flushes and clears.
    do_write(4'hE, 8'h31, "push_partial");
    do_write(4'h0, 8'h02, "flush");
    do_write(4'hE, 8'h9A, "direct_after");
    check("mix_after", 32'(mix), qsum());

    // Asynchronous reset mid-stream, strobe held across release.
    reset = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    check("async_rst_mix", 32'(mix), 32'd512);
    iorq = 1'b0; wr = 1'b0; a = 8'hDF; d = 8'h11;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check_all("rst_release");
    iorq = 1'b1; wr = 1'b1;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
